// File: rtl/oled_video_ssd1331.sv
// oled_video_ssd1331: SPI master for the SSD1331 OLED: panel reset, init command bytes, then an endless pixel stream.
// Init bytes come from C_init_data (byte 0 in bits [7:0]), the packed image of C_init_file.
module oled_video_ssd1331 #(
    parameter              C_init_file  = "oled_init.mem",
    parameter int          C_init_size  = 44,
    parameter logic [8*C_init_size-1:0] C_init_data = '0,
    parameter int          C_reset_clks = 1024,
    parameter int          C_x_size     = 96,
    parameter int          C_y_size     = 64,
    parameter int          C_x_bits     = 7,
    parameter int          C_y_bits     = 6,
    parameter int          C_color_bits = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [C_color_bits-1:0] color,
    output logic [C_x_bits-1:0]     x,
    output logic [C_y_bits-1:0]     y,
    output logic                    next_pixel,
    output logic                    spi_csn,
    output logic                    spi_clk,
    output logic                    spi_mosi,
    output logic                    spi_dc,
    output logic                    spi_resn
);
    localparam int RW = $clog2(C_reset_clks + 1);
    localparam int AW = $clog2(C_init_size + 1);
    localparam int BW = $clog2(C_color_bits);
    localparam logic [RW-1:0]       CNT_LAST = RW'(C_reset_clks - 1);
    localparam logic [BW-1:0]       BIT_PX   = BW'(C_color_bits - 1);
    localparam logic [BW-1:0]       BIT_CMD  = BW'(7);
    localparam logic [C_x_bits-1:0] X_LAST   = C_x_bits'(C_x_size - 1);
    localparam logic [C_y_bits-1:0] Y_LAST   = C_y_bits'(C_y_size - 1);

    if (C_color_bits != 8 && C_color_bits != 16) begin : g_bad_color
        $error("C_color_bits must be 8 or 16");
    end
    if (C_init_size < 1) begin : g_bad_init
        $error("%s: C_init_size must be >= 1", C_init_file);
    end

    typedef enum logic [1:0] {RST_LOW, RST_WAIT, INIT, DATA} state_t;

    state_t                  state_q;
    logic [RW-1:0]           cnt_q;
    logic [AW-1:0]           rom_addr_q;
    logic [7:0]              rom_data_q;
    logic [BW-1:0]           bit_q;
    logic                    phase_q;
    logic [C_color_bits-1:0] shift_q;
    logic [C_x_bits-1:0]     x_q;
    logic [C_y_bits-1:0]     y_q;
    logic                    next_pixel_q;
    logic                    csn_q;
    logic                    dc_q;
    logic                    resn_q;

    logic [7:0]              rom_rd;
    logic [BW-1:0]           bit_last;
    logic                    last_byte;
    logic [C_color_bits-1:0] cmd_word;
    logic [C_x_bits-1:0]     x_d;
    logic [C_y_bits-1:0]     y_d;

    always_comb begin
        rom_rd = '0;
        for (int i = 0; i < C_init_size; i++)
            rom_rd = (rom_addr_q == AW'(i)) ? C_init_data[8*i +: 8] : rom_rd;
    end

    always_comb begin
        bit_last  = (state_q == DATA) ? BIT_PX : BIT_CMD;
        last_byte = rom_addr_q == AW'(C_init_size);
        cmd_word  = C_color_bits'(rom_data_q) << (C_color_bits - 8);
        x_d       = (x_q == X_LAST) ? '0 : x_q + 1'b1;
        y_d       = (x_q == X_LAST) ? ((y_q == Y_LAST) ? '0 : y_q + 1'b1) : y_q;
    end

    // rom_addr_q always points at the next byte to send, so rom_data_q is ready before it is needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_LOW;
            cnt_q        <= '0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            bit_q        <= '0;
            phase_q      <= 1'b0;
            shift_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            next_pixel_q <= 1'b0;
            csn_q        <= 1'b1;
            dc_q         <= 1'b0;
            resn_q       <= 1'b0;
        end else begin
            rom_data_q   <= rom_rd;
            next_pixel_q <= 1'b0;
            case (state_q)
                RST_LOW: begin
                    cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        resn_q  <= 1'b1;
                        state_q <= RST_WAIT;
                    end
                end
                RST_WAIT: begin
                    cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        csn_q      <= 1'b0;
                        shift_q    <= cmd_word;
                        rom_addr_q <= rom_addr_q + 1'b1;
                        state_q    <= INIT;
                    end
                end
                INIT, DATA: begin
                    phase_q <= ~phase_q;
                    if (!phase_q) begin
                        next_pixel_q <= (bit_q == bit_last) && (state_q == DATA || last_byte);
                    end else if (next_pixel_q) begin
                        // the strobe cycle: take the pixel colour and step to the next coordinate
                        shift_q <= color;
                        bit_q   <= '0;
                        dc_q    <= 1'b1;
                        x_q     <= x_d;
                        y_q     <= y_d;
                        state_q <= DATA;
                    end else if (bit_q == bit_last) begin
                        shift_q    <= cmd_word;
                        bit_q      <= '0;
                        rom_addr_q <= rom_addr_q + 1'b1;
                    end else begin
                        shift_q <= shift_q << 1;
                        bit_q   <= bit_q + 1'b1;
                    end
                end
                default: state_q <= RST_LOW;
            endcase
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign next_pixel = next_pixel_q;
    assign spi_csn    = csn_q;
    assign spi_clk    = phase_q;
    assign spi_mosi   = shift_q[C_color_bits-1];
    assign spi_dc     = dc_q;
    assign spi_resn   = resn_q;
endmodule
